// File: rtl/if_pkg.sv
// if_pkg: shared state, entry type and constants for the instruction fetch unit
package if_pkg;
  typedef enum logic {FETCH, HALT} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch entries with flush; storage clears on reset
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = din;
    wr_d  = flush ? '0 : wr_q + AW'(push);
    rd_d  = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout  = mem_q[rd_q];
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner and prefetcher feeding decode over valid/ready.
// FETCH_FAULT_EN adds out_fault and pushes a NOP fault entry for misaligned or out-of-range PCs.
module inst_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_BYTES = 88
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
`ifdef FETCH_FAULT_EN
  output logic        out_fault,
`endif
  output logic        halted
);
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  fetch_entry_t din, head;
  logic push, pop, full, empty, space, in_range;
  logic [$clog2(FIFO_DEPTH):0] unused_count;
  assign pop      = !empty && out_ready;
  assign space    = !full || pop;
  assign in_range = pc_q <= LAST_PC;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    din     = '{pc: pc_q, instr: imem_rdata, fault: 1'b0};
    if (redirect_valid) begin
      state_d = FETCH;
`ifdef FETCH_FAULT_EN
      pc_d    = redirect_pc;
`else
      pc_d    = {redirect_pc[31:2], 2'b00};
`endif
    end else if (state_q == FETCH) begin
`ifdef FETCH_FAULT_EN
      if (!in_range || pc_q[1:0] != 2'b00) begin
        push      = space;
        din.instr = NOP_INSTR;
        din.fault = 1'b1;
        state_d   = space ? HALT : FETCH;
      end else begin
        push = space;
        pc_d = space ? pc_q + 32'd4 : pc_q;
      end
`else
      if (!in_range) state_d = HALT;
      else begin
        push = space;
        pc_d = space ? pc_q + 32'd4 : pc_q;
      end
`endif
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  (din),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(unused_count)
  );
  assign imem_addr = pc_q;
  assign out_valid = !empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign halted    = state_q == HALT;
`ifdef FETCH_FAULT_EN
  assign out_fault = head.fault;
`else
  logic unused_fault;
  assign unused_fault = head.fault;
`endif
endmodule
